// File: rtl/seg7_pkg.sv
// Shared definitions for active-low 7-segment display readers.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned VAL_W = 4;

  // Active-low digit patterns, bit6 = segment g, bit0 = segment a
  localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h00;

  // Sign digit patterns
  localparam logic [SEG_W-1:0] SEG_MINUS = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Decoder FSM states
  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    HOLD   = 1'b1
  } state_t;

  // Sign/magnitude display pair as sampled from the pins
  typedef struct packed {
    logic [SEG_W-1:0] sign;
    logic [SEG_W-1:0] mag;
  } seg_pair_t;

  // Value the pair history holds out of reset: both digits dark
  localparam seg_pair_t PAIR_RESET = {SEG_BLANK, SEG_BLANK};

  // 4-bit modulo negation; no sign extension, so -8 wraps to 4'h8
  function automatic logic [VAL_W-1:0] neg_mod(input logic [VAL_W-1:0] m);
    return (~m) + VAL_W'(1);
  endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Maps an active-low 7-segment pattern to its digit value 0..8.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] i_pattern,
  output logic [VAL_W-1:0] o_mag_c,
  output logic             o_hit_c
);

  // Pattern lookup; any unlisted pattern is reported as a miss
  always_comb begin
    o_mag_c = '0;
    o_hit_c = 1'b1;
    case (i_pattern)
      SEG_0:   o_mag_c = VAL_W'(0);
      SEG_1:   o_mag_c = VAL_W'(1);
      SEG_2:   o_mag_c = VAL_W'(2);
      SEG_3:   o_mag_c = VAL_W'(3);
      SEG_4:   o_mag_c = VAL_W'(4);
      SEG_5:   o_mag_c = VAL_W'(5);
      SEG_6:   o_mag_c = VAL_W'(6);
      SEG_7:   o_mag_c = VAL_W'(7);
      SEG_8:   o_mag_c = VAL_W'(8);
      default: o_hit_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_to_tc4.sv
// Sign/magnitude 7-segment pair receiver: waits for a stable pair, then
// recovers the 4-bit two's complement value or flags an illegal encoding.
module seg7_to_tc4
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 4
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic [SEG_W-1:0] Sign,
  input  logic [SEG_W-1:0] Magnitude,
  output logic [VAL_W-1:0] N,
  output logic             Valid,
  output logic             Error,
  output logic             Locked
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  seg_pair_t        r_prev;
  logic [CNT_W-1:0] r_cnt;

  seg_pair_t        w_pair;
  logic             w_same;
  logic             w_fire;

  logic [VAL_W-1:0] w_mag;
  logic             w_hit;
  logic             w_legal;
  logic [VAL_W-1:0] w_val;

  logic [VAL_W-1:0] w_n_nxt;
  logic             w_valid_nxt;
  logic             w_error_nxt;
  logic             w_locked_nxt;

  assign w_pair = {Sign, Magnitude};
  assign w_same = (w_pair == r_prev);
  // Decode edge: the pair has been seen on STABLE_CYCLES consecutive edges
  assign w_fire = (r_state == SETTLE) && w_same && (r_cnt == CNT_LAST);

  seg7_digit_decode u_digit (
    .i_pattern (Magnitude),
    .o_mag_c   (w_mag),
    .o_hit_c   (w_hit)
  );

  // Sign/digit legality and value recovery
  always_comb begin
    w_legal = 1'b0;
    w_val   = w_mag;
    if (w_hit) begin
      if ((Sign == SEG_BLANK) && (w_mag != VAL_W'(8))) begin
        w_legal = 1'b1;
        w_val   = w_mag;
      end else if ((Sign == SEG_MINUS) && (w_mag != VAL_W'(0))) begin
        w_legal = 1'b1;
        w_val   = neg_mod(w_mag);
      end
    end
  end

  // State register
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_state <= SETTLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: any change of pair restarts settling
  always_comb begin
    w_state_nxt = r_state;
    if (!w_same) begin
      w_state_nxt = SETTLE;
    end else if (w_fire) begin
      w_state_nxt = HOLD;
    end
  end

  // Pair history and saturating stability counter
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_prev <= PAIR_RESET;
      r_cnt  <= '0;
    end else if (!w_same) begin
      r_prev <= w_pair;
      r_cnt  <= CNT_W'(1);
    end else if ((r_state == SETTLE) && (r_cnt != CNT_LAST)) begin
      r_cnt  <= r_cnt + CNT_W'(1);
    end
  end

  // Output decode: one pulse per decode, N only updated on a legal pair
  always_comb begin
    w_n_nxt      = N;
    w_valid_nxt  = 1'b0;
    w_error_nxt  = 1'b0;
    w_locked_nxt = (w_state_nxt == HOLD);
    if (w_fire) begin
      if (w_legal) begin
        w_n_nxt     = w_val;
        w_valid_nxt = 1'b1;
      end else begin
        w_error_nxt = 1'b1;
      end
    end
  end

  // Output registers
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      N      <= '0;
      Valid  <= 1'b0;
      Error  <= 1'b0;
      Locked <= 1'b0;
    end else begin
      N      <= w_n_nxt;
      Valid  <= w_valid_nxt;
      Error  <= w_error_nxt;
      Locked <= w_locked_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_to_tc4.sv
// Bench for seg7_to_tc4: run-length reference model plus directed scenarios.
module tb_seg7_to_tc4;

  localparam int STABLE = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] sign  = 7'h7F;
  logic [6:0] mag   = 7'h7F;
  logic [3:0] n_o;
  logic       valid_o;
  logic       error_o;
  logic       locked_o;

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;
  int ecnt   = 0;

  seg7_to_tc4 #(.STABLE_CYCLES(STABLE), .CNT_W(4)) dut (
    .Clock     (clk),
    .ResetN    (rst_n),
    .Sign      (sign),
    .Magnitude (mag),
    .N         (n_o),
    .Valid     (valid_o),
    .Error     (error_o),
    .Locked    (locked_o)
  );

  always #5 clk = ~clk;

  // Digit table indexed by value
  logic [6:0] digits [9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_decode(input logic [6:0] s, input logic [6:0] m,
                                     output bit legal, output logic [3:0] val);
    int idx;
    idx = -1;
    for (int d = 0; d < 9; d++) if (digits[d] == m) idx = d;
    legal = 1'b0;
    val   = 4'h0;
    if (idx >= 0) begin
      if (s == 7'h7F && idx <= 7) begin
        legal = 1'b1;
        val   = 4'(idx);
      end else if (s == 7'h3F && idx >= 1) begin
        legal = 1'b1;
        val   = 4'((16 - idx) % 16);
      end
    end
  endfunction

  // Reference model: length of the current run of identical pairs
  logic [13:0] m_prev   = {7'h7F, 7'h7F};
  int          m_run    = 0;
  logic [3:0]  m_n      = 4'h0;
  bit          m_valid  = 1'b0;
  bit          m_error  = 1'b0;
  bit          m_locked = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit         lg;
    logic [3:0] v;
    if (!rst_n) begin
      m_prev = {7'h7F, 7'h7F};
      m_run = 0; m_n = 4'h0; m_valid = 0; m_error = 0; m_locked = 0;
    end else begin
      m_valid = 0;
      m_error = 0;
      if ({sign, mag} == m_prev) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_prev = {sign, mag};
        m_run  = 1;
      end
      if (m_run == STABLE) begin
        ref_decode(sign, mag, lg, v);
        if (lg) begin
          m_n = v;
          m_valid = 1;
        end else begin
          m_error = 1;
        end
      end
      m_locked = (m_run >= STABLE);
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("N", int'(n_o), int'(m_n));
    check("Valid", int'(valid_o), int'(m_valid));
    check("Error", int'(error_o), int'(m_error));
    check("Locked", int'(locked_o), int'(m_locked));
    if (valid_o === 1'b1) vcnt++;
    if (error_o === 1'b1) ecnt++;
  end

  task automatic hold(input logic [6:0] s, input logic [6:0] m, input int cycles);
    sign = s;
    mag  = m;
    repeat (cycles) @(negedge clk);
    #1;
  endtask

  logic [6:0] sw_sign [16] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
                               7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  logic [6:0] sw_mag  [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
  logic [3:0] sw_n    [16] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                               4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};

  initial begin
    int v0;
    int e0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_N", int'(n_o), 0);
    check("rst_Valid", int'(valid_o), 0);
    check("rst_Error", int'(error_o), 0);
    check("rst_Locked", int'(locked_o), 0);
    rst_n = 1'b1;

    // Blank + 3 held: one Valid, N=3, stays locked without repeats
    v0 = vcnt; e0 = ecnt;
    hold(7'h7F, 7'h30, 10);
    check("t1_N", int'(n_o), 3);
    check("t1_Locked", int'(locked_o), 1);
    check("t1_valid_count", vcnt - v0, 1);
    check("t1_error_count", ecnt - e0, 0);

    // Minus 8 then minus 1
    v0 = vcnt;
    hold(7'h3F, 7'h00, 6);
    check("t2_N_minus8", int'(n_o), 8);
    hold(7'h3F, 7'h79, 6);
    check("t2_N_minus1", int'(n_o), 15);
    check("t2_valid_count", vcnt - v0, 2);

    // Glitching digits never settle
    v0 = vcnt; e0 = ecnt;
    for (int r = 0; r < 4; r++) begin
      hold(7'h7F, 7'h12, 3);
      hold(7'h7F, 7'h02, 3);
    end
    check("t3_valid_count", vcnt - v0, 0);
    check("t3_error_count", ecnt - e0, 0);
    check("t3_Locked", int'(locked_o), 0);

    // Illegal pairs keep the preloaded value
    hold(7'h7F, 7'h12, 5);
    check("t4_preload_N", int'(n_o), 5);
    v0 = vcnt; e0 = ecnt;
    hold(7'h3F, 7'h40, 5);
    hold(7'h7F, 7'h00, 5);
    hold(7'h7F, 7'h7F, 5);
    check("t4_error_count", ecnt - e0, 3);
    check("t4_valid_count", vcnt - v0, 0);
    check("t4_N_kept", int'(n_o), 5);

    // Sweep of all legal pairs
    v0 = vcnt;
    for (int i = 0; i < 16; i++) begin
      hold(sw_sign[i], sw_mag[i], 5);
      check($sformatf("t5_N_%0d", i), int'(n_o), int'(sw_n[i]));
    end
    check("t5_valid_count", vcnt - v0, 16);

    // Reset during settling of minus 4
    hold(7'h3F, 7'h19, 2);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_N", int'(n_o), 0);
    check("t6_rst_Locked", int'(locked_o), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    v0 = vcnt;
    repeat (4) @(negedge clk);
    #1;
    check("t6_early_Valid", int'(valid_o), 0);
    check("t6_early_count", vcnt - v0, 0);
    @(negedge clk);
    #1;
    check("t6_Valid", int'(valid_o), 1);
    check("t6_N", int'(n_o), 12);
    check("t6_Locked", int'(locked_o), 1);

    repeat (3) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
